// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, counter type and window helper
// shared by the VGA sync generator and downstream pixel-rate stages.
package vga_timing_pkg;
    localparam int CNT_W      = 11;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int H_ACTIVE_D = 640;
    localparam int H_TOTAL_D  = 800;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int V_ACTIVE_D = 480;
    localparam int V_TOTAL_D  = 525;

    localparam int H_VIS_START = H_SYNC_D + H_BP_D;
    localparam int H_VIS_END   = H_VIS_START + H_ACTIVE_D;
    localparam int V_VIS_START = V_SYNC_D + V_BP_D;
    localparam int V_VIS_END   = V_VIS_START + V_ACTIVE_D;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test [lo, hi), unsigned.
    function automatic logic in_range(cnt_t x, cnt_t lo, cnt_t hi);
        return (x >= lo) && (x < hi);
    endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock down to a one-clock pixel enable
// every CLK_DIV clocks; constantly high when CLK_DIV is 1.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] div_cnt_q, div_cnt_d;

    assign pixel_tick = (div_cnt_q == W'(CLK_DIV - 1));

    always_comb div_cnt_d = pixel_tick ? '0 : div_cnt_q + W'(1);

    always_ff @(posedge clk) begin
        if (!reset) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end
endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA position counters with registered sync, active-video and pixel
// coordinate outputs, all aligned to the current counter values.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_TOTAL  = H_TOTAL_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_TOTAL  = V_TOTAL_D
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] h_counter,
    output logic [10:0] v_counter,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_tick,
    output logic        frame_start
);
    localparam cnt_t H_S    = cnt_t'(H_SYNC);
    localparam cnt_t H_VS   = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t H_VE   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_S    = cnt_t'(V_SYNC);
    localparam cnt_t V_VS   = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t V_VE   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    cnt_t       h_q, h_d, v_q, v_d;
    logic       hsync_q, vsync_q, video_on_q, frame_start_q;
    logic       video_on_d, frame_start_d, h_wrap, v_wrap;
    logic [9:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick)
    );

    // Decodes use next-state counters so registered outputs line up with h_q/v_q.
    always_comb begin
        h_wrap        = (h_q == H_LAST);
        v_wrap        = (v_q == V_LAST);
        h_d           = pixel_tick ? (h_wrap ? '0 : h_q + cnt_t'(1)) : h_q;
        v_d           = (pixel_tick && h_wrap) ? (v_wrap ? '0 : v_q + cnt_t'(1)) : v_q;
        video_on_d    = in_range(h_d, H_VS, H_VE) && in_range(v_d, V_VS, V_VE);
        pixel_x_d     = video_on_d ? 10'(h_d - H_VS) : '0;
        pixel_y_d     = video_on_d ? 10'(v_d - V_VS) : '0;
        frame_start_d = pixel_tick && h_wrap && v_wrap;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= (h_d >= H_S);
            vsync_q       <= (v_d >= V_S);
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of a default-timing instance (CLK_DIV=4) and a
// shrunken-timing instance (CLK_DIV=1, 20x12 raster) for full-frame behaviour.
module tb_vga_sync;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [10:0] a_h, a_v, b_h, b_v;
    logic [9:0]  a_px, a_py, b_px, b_py;
    logic        a_hs, a_vs, a_vid, a_tick, a_fs;
    logic        b_hs, b_vs, b_vid, b_tick, b_fs;

    vga_sync #(.CLK_DIV(4)) u_a (
        .clk(clk), .reset(rst_a), .h_counter(a_h), .v_counter(a_v),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vid), .pixel_x(a_px),
        .pixel_y(a_py), .pixel_tick(a_tick), .frame_start(a_fs)
    );

    // Small raster: visible h 7..16, v 4..8; 240 clocks per frame.
    vga_sync #(
        .CLK_DIV(1), .H_SYNC(4), .H_BP(3), .H_ACTIVE(10), .H_TOTAL(20),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_TOTAL(12)
    ) u_b (
        .clk(clk), .reset(rst_b), .h_counter(b_h), .v_counter(b_v),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vid), .pixel_x(b_px),
        .pixel_y(b_py), .pixel_tick(b_tick), .frame_start(b_fs)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, " h"}, a_h, 0);
        chk({tag, " v"}, a_v, 0);
        chk({tag, " hsync"}, a_hs, 0);
        chk({tag, " vsync"}, a_vs, 0);
        chk({tag, " video_on"}, a_vid, 0);
        chk({tag, " px"}, a_px, 0);
        chk({tag, " py"}, a_py, 0);
        chk({tag, " tick"}, a_tick, 0);
        chk({tag, " fs"}, a_fs, 0);
    endtask

    initial begin
        int ticks, hs_low, vid_cnt, tick_err, hv_err, vid_err, vs_low, fs_cnt, b_ticks;
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(3);
        chk_a_reset("por");
        chk("por b tick", b_tick, 1);
        chk("por b h", b_h, 0);

        rst_a = 1'b1;
        chk("rel tick k0", a_tick, 0);
        step(3);
        chk("rel tick k3", a_tick, 1);
        chk("rel h k3", a_h, 0);
        step(1);
        chk("rel h k4", a_h, 1);
        chk("rel tick k4", a_tick, 0);

        step(1596);
        chk("mid h", a_h, 400);
        chk("mid v", a_v, 0);
        chk("mid hsync", a_hs, 1);
        chk("mid video_on", a_vid, 0);

        rst_a = 1'b0;
        step(1);
        chk_a_reset("midrst");
        step(2);
        chk("midrst hold h", a_h, 0);
        chk("midrst hold fs", a_fs, 0);
        rst_a = 1'b1;
        step(4);
        chk("midrst rel h", a_h, 1);

        rst_a = 1'b0;
        step(1);
        rst_a = 1'b1;
        ticks = 0; hs_low = 0; vid_cnt = 0; tick_err = 0;
        for (int i = 0; i < 3200; i++) begin
            ticks += int'(a_tick);
            hs_low += int'(!a_hs);
            vid_cnt += int'(a_vid);
            tick_err += int'(a_tick != ((i % 4) == 3));
            if (i == 383) chk("hsync h95", a_hs, 0);
            if (i == 384) chk("hsync h96", a_hs, 1);
            if (i == 3199) begin
                chk("line end h", a_h, 799);
                chk("line end v", a_v, 0);
            end
            step(1);
        end
        chk("line ticks", ticks, 800);
        chk("line tick pattern errs", tick_err, 0);
        chk("line hsync low clocks", hs_low, 384);
        chk("line0 video_on", vid_cnt, 0);
        chk("wrap h", a_h, 0);
        chk("wrap v", a_v, 1);

        rst_b = 1'b1;
        hv_err = 0; vid_err = 0; vs_low = 0; vid_cnt = 0; fs_cnt = 0; b_ticks = 0;
        for (int k = 0; k < 480; k++) begin
            int eh, ev;
            eh = k % 20;
            ev = (k / 20) % 12;
            hv_err += int'(b_h != 11'(eh) || b_v != 11'(ev));
            vid_err += int'(b_vid != (eh >= 7 && eh < 17 && ev >= 4 && ev < 9));
            b_ticks += int'(b_tick);
            fs_cnt += int'(b_fs);
            if (k < 240) begin
                vs_low += int'(!b_vs);
                vid_cnt += int'(b_vid);
            end
            if (k == 87) begin
                chk("vis first vid", b_vid, 1);
                chk("vis first px", b_px, 0);
                chk("vis first py", b_py, 0);
            end
            if (k == 176) begin
                chk("vis last px", b_px, 9);
                chk("vis last py", b_py, 4);
            end
            if (k == 177) begin
                chk("vis fall vid", b_vid, 0);
                chk("vis fall px", b_px, 0);
            end
            if (k == 239) begin
                chk("frame end h", b_h, 19);
                chk("frame end v", b_v, 11);
            end
            if (k == 240) begin
                chk("frame wrap fs", b_fs, 1);
                chk("frame wrap hsync", b_hs, 0);
                chk("frame wrap vsync", b_vs, 0);
                chk("frame wrap vid", b_vid, 0);
            end
            if (k == 241) chk("frame fs width", b_fs, 0);
            step(1);
        end
        chk("b hv errs", hv_err, 0);
        chk("b video errs", vid_err, 0);
        chk("b tick always", b_ticks, 480);
        chk("b vsync low clocks", vs_low, 40);
        chk("b visible pixels", vid_cnt, 50);
        chk("b frame_start count", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
